// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port instruction/data memory between the fetch stage and
// the load/store unit. One memory transaction is outstanding at a time: the
// arbiter picks a winner in IDLE, presents it to memory, then waits in
// WAIT_F / WAIT_D for the single response and routes it back to its owner.
//
// Handshake rules used on every port of this block:
//   - A requester raises *_req with its address/data and holds all of them
//     stable until it sees its *_gnt. *_gnt is combinational and means "the
//     memory took your request this cycle".
//   - Toward memory, a transfer happens in the cycle where m_req & m_ready.
//     Once m_req is raised, the winner and m_we/m_addr/m_wdata/m_be stay
//     stable until accepted (except a fetch redirect, see f_flush).
//   - m_rvalid / f_rvalid / d_rvalid are single-cycle pulses carrying the
//     response; there is no back-pressure on responses.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   f_req/f_addr         fetch read request and PC
//   f_flush              fetch redirect: drop any in-flight fetch response
//   f_gnt/f_rvalid/f_rdata  fetch accept, response valid, instruction word
//   fetch_stall          hold PC (= ~f_rvalid)
//   d_req/d_we/d_addr/d_wdata/d_be  load/store request
//   d_gnt/d_rvalid/d_rdata  data accept, load data / store ack
//   m_req/m_we/m_addr/m_wdata/m_be/m_ready  memory request side
//   m_rvalid/m_rdata     memory response side
//   dbg_state/dbg_starve_cnt/dbg_lock/dbg_discard  internal state visibility
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  // fetch port
  input  logic             f_req,
  input  logic [XLEN-1:0]  f_addr,
  input  logic             f_flush,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [XLEN-1:0]  f_rdata,
  output logic             fetch_stall,
  // load/store port
  input  logic             d_req,
  input  logic             d_we,
  input  logic [XLEN-1:0]  d_addr,
  input  logic [XLEN-1:0]  d_wdata,
  input  logic [3:0]       d_be,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [XLEN-1:0]  d_rdata,
  // memory port
  output logic             m_req,
  output logic             m_we,
  output logic [XLEN-1:0]  m_addr,
  output logic [XLEN-1:0]  m_wdata,
  output logic [3:0]       m_be,
  input  logic             m_ready,
  input  logic             m_rvalid,
  input  logic [XLEN-1:0]  m_rdata,
  // debug visibility
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt,
  output logic             dbg_lock,
  output logic             dbg_discard
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_F = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_next;
  logic             lock, lock_next;
  logic             owner_d, owner_d_next;   // latched winner while locked: 1 = data
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             discard, discard_next;

  // arbitration
  logic req_any;
  logic lock_eff;
  logic win_d;

  // -------------------------------------------------------------------------
  // Winner selection (only meaningful in IDLE).
  // A lock normally pins the winner. It is dropped when fetch is the owner
  // and gets redirected, and also if the owner withdraws its request, so a
  // misbehaving requester can never leave m_req driven for a port that is
  // no longer asking.
  // -------------------------------------------------------------------------
  always_comb begin
    req_any  = f_req | d_req;
    lock_eff = lock
             & ~(~owner_d & f_flush)
             & (owner_d ? d_req : f_req);
    if (lock_eff) begin
      win_d = owner_d;
    end else if (f_req && d_req) begin
      win_d = (starve_cnt != LIMIT);
    end else begin
      win_d = d_req;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lock       <= 1'b0;
      owner_d    <= 1'b0;
      starve_cnt <= '0;
      discard    <= 1'b0;
    end else begin
      state      <= state_next;
      lock       <= lock_next;
      owner_d    <= owner_d_next;
      starve_cnt <= starve_next;
      discard    <= discard_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    lock_next    = lock;
    owner_d_next = owner_d;
    starve_next  = starve_cnt;
    discard_next = discard;

    case (state)
      IDLE: begin
        lock_next    = lock_eff;
        discard_next = 1'b0;
        if (req_any) begin
          if (m_ready) begin
            state_next = win_d ? WAIT_D : WAIT_F;
            lock_next  = 1'b0;
          end else begin
            lock_next    = 1'b1;
            owner_d_next = win_d;
          end
        end
        // Count data wins that happened while fetch was waiting.
        if (f_gnt) begin
          starve_next = '0;
        end else if (d_gnt && f_req && (starve_cnt != LIMIT)) begin
          starve_next = starve_cnt + 1'b1;
        end
      end

      WAIT_F: begin
        if (f_flush) begin
          discard_next = 1'b1;
        end
        if (m_rvalid) begin
          state_next   = IDLE;
          discard_next = 1'b0;
        end
      end

      WAIT_D: begin
        if (m_rvalid) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs. Everything handshake-related is forced inactive during reset so
  // the memory never sees a request while the arbiter is being initialised.
  // -------------------------------------------------------------------------
  always_comb begin
    m_req    = 1'b0;
    m_we     = 1'b0;
    m_addr   = f_addr;
    m_wdata  = '0;
    m_be     = 4'hF;
    f_gnt    = 1'b0;
    d_gnt    = 1'b0;
    f_rvalid = 1'b0;
    d_rvalid = 1'b0;
    f_rdata  = m_rdata;
    d_rdata  = m_rdata;

    if (!reset) begin
      case (state)
        IDLE: begin
          m_req = req_any;
          if (win_d) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
          end
          f_gnt = req_any & m_ready & ~win_d;
          d_gnt = req_any & m_ready &  win_d;
        end
        WAIT_F: begin
          // A redirect in the response cycle itself also kills the word.
          f_rvalid = m_rvalid & ~discard & ~f_flush;
        end
        WAIT_D: begin
          d_rvalid = m_rvalid;
        end
        default: begin
        end
      endcase
    end

    fetch_stall = ~f_rvalid;
  end

  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;
  assign dbg_lock       = lock;
  assign dbg_discard    = discard;

endmodule
